vga_image_fetch: RTL

//  VGA-side read stage for the image RAM (300x300 8-bit grayscale, 4 pixels per 32-bit word).
//  - Takes timing (hcount/vcount/video_on/syncs) from the VGA controller.
//  - Drives the RAM word address and receives the read word (RAM has 1-clk read latency).
//  - Selects the byte lane and emits RGB plus syncs delayed to match, centred in 640x480.

---
 rtl/vga_img_pkg.sv | 18 +
 rtl/image_window_ctr.sv | 32 +++
 rtl/vga_image_fetch.sv | 68 ++++++
 3 files changed

// File: rtl/vga_img_pkg.sv
// vga_img_pkg: shared constants and types for the VGA image fetch path
package vga_img_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int IMG_W = 300;
  localparam int IMG_H = 300;
  localparam int PIX_PER_WORD = 4;
  localparam int LANE_W = $clog2(PIX_PER_WORD);
  localparam int IDX_W = 17;
  typedef struct packed {
    logic [7:0] r, g, b;
  } rgb_t;
  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic win, von, hs, vs;
  } s1_t;
  localparam s1_t S1_RST = '{lane: '0, win: 1'b0, von: 1'b0, hs: 1'b1, vs: 1'b1};
endpackage

// File: rtl/image_window_ctr.sv
// image_window_ctr: image window decode and row-major pixel index counter
module image_window_ctr import vga_img_pkg::*; #(
  parameter int IMG_W = vga_img_pkg::IMG_W,
  parameter int IMG_H = vga_img_pkg::IMG_H,
  parameter int X0 = (H_ACTIVE - vga_img_pkg::IMG_W) / 2,
  parameter int Y0 = (V_ACTIVE - vga_img_pkg::IMG_H) / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  input  logic             video_on,
  output logic [IDX_W-1:0] cur,
  output logic             win
);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(IMG_W * IMG_H - 1);
  logic [IDX_W-1:0] idx_q, idx_d;
  logic frame_start;
  // window test, frame restart and saturating index advance
  always_comb begin
    win = video_on && hcount >= 10'(X0) && hcount < 10'(X0 + IMG_W) &&
          vcount >= 10'(Y0) && vcount < 10'(Y0 + IMG_H);
    frame_start = pix_en && hcount == 10'd0 && vcount == 10'd0;
    cur = frame_start ? '0 : idx_q;
    idx_d = !pix_en ? idx_q : (win && cur != IDX_MAX) ? cur + 1'b1 : cur;
  end
  // index register
  always_ff @(posedge clk)
    if (rst) idx_q <= '0;
    else idx_q <= idx_d;
endmodule

// File: rtl/vga_image_fetch.sv
// vga_image_fetch: two-stage image RAM read and byte-lane select for VGA output
module vga_image_fetch import vga_img_pkg::*; #(
  parameter int          IMG_W = vga_img_pkg::IMG_W,
  parameter int          IMG_H = vga_img_pkg::IMG_H,
  parameter int          X0 = 170,
  parameter int          Y0 = 90,
  parameter int          ADDR_W = 18,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_data,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              blank_n,
  output logic              hsync,
  output logic              vsync
);
  logic [IDX_W-1:0] cur;
  logic win;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  s1_t s1_q, s1_d;
  rgb_t rgb_q, rgb_d;
  logic [2:0] ctl_q, ctl_d;
  logic [7:0] gray;
  image_window_ctr #(.IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0)) u_ctr (
    .clk(clk),
    .rst(rst),
    .pix_en(pix_en),
    .hcount(hcount),
    .vcount(vcount),
    .video_on(video_on),
    .cur(cur),
    .win(win)
  );
  // stage 1 issues the word address and tags; stage 2 picks the lane once the word has arrived
  always_comb begin
    gray = ram_data[{s1_q.lane, 3'b000} +: 8];
    ram_addr_d = (pix_en && win) ? ADDR_W'(cur[IDX_W-1:LANE_W]) : ram_addr_q;
    s1_d = pix_en ? s1_t'{lane: cur[LANE_W-1:0], win: win, von: video_on, hs: hsync_in, vs: vsync_in} : s1_q;
    rgb_d = !pix_en ? rgb_q : s1_q.win ? rgb_t'{gray, gray, gray} : s1_q.von ? rgb_t'(BORDER_RGB) : '0;
    ctl_d = pix_en ? {s1_q.von, s1_q.hs, s1_q.vs} : ctl_q;
  end
  // pipeline registers; syncs idle high
  always_ff @(posedge clk)
    if (rst) begin
      ram_addr_q <= '0;
      s1_q <= S1_RST;
      rgb_q <= '0;
      ctl_q <= 3'b011;
    end else begin
      ram_addr_q <= ram_addr_d;
      s1_q <= s1_d;
      rgb_q <= rgb_d;
      ctl_q <= ctl_d;
    end
  assign ram_addr = ram_addr_q;
  assign {red, green, blue} = rgb_q;
  assign {blank_n, hsync, vsync} = ctl_q;
endmodule
